// File: rtl/ble_ring_reader_if.sv
// Bus bundle for ble_ring_reader: Wishbone read port toward the shared RAM
// and the start/done handshake toward uart_tx.
interface ble_ring_reader_if #(
    parameter int BITS = 8
);
    logic [31:0]     wb_adr;
    logic            wb_cyc;
    logic            wb_we;
    logic [3:0]      wb_sel;
    logic [31:0]     wb_rdt;
    logic            wb_ack;
    logic [BITS-1:0] tx_dat;
    logic            tx_start;
    logic            tx_done;

    modport master (
        output wb_adr, wb_cyc, wb_we, wb_sel, tx_dat, tx_start,
        input  wb_rdt, wb_ack, tx_done
    );

    modport slave (
        input  wb_adr, wb_cyc, wb_we, wb_sel, tx_dat, tx_start,
        output wb_rdt, wb_ack, tx_done
    );
endinterface

// File: rtl/ble_ring_reader.sv
// Drains the BLE rx ring (ADR_LL..ADR_UL, one byte per word) and forwards each byte to uart_tx.
// Define RING_RD_TIMEOUT_EN to add a READ/WAIT watchdog with sticky o_err.
module ble_ring_reader #(
    parameter logic [31:0] ADR_LL = 32'h00C0_0000,
    parameter logic [31:0] ADR_UL = 32'h00C1_0000,
    parameter int          BITS   = 8,
    parameter int          CNT_W  = 16
`ifdef RING_RD_TIMEOUT_EN
    ,
    parameter int          TIMEOUT = 4096
`endif
) (
    input  logic                 i_wb_clk,
    input  logic                 i_wb_rst,
    input  logic                 i_en,
    input  logic                 i_flush,
    input  logic [31:0]          i_wr_ptr,
    ble_ring_reader_if.master    bus,
    output logic                 o_empty,
    output logic                 o_busy,
    output logic [CNT_W-1:0]     o_sent
`ifdef RING_RD_TIMEOUT_EN
    ,
    output logic                 o_err
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_SEND = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [31:0]      rd_ptr_r;
    logic [31:0]      rd_ptr_adv_s;
    logic             flush_pend_r;
    logic [BITS-1:0]  tx_dat_r;
    logic [CNT_W-1:0] sent_r;
    logic             cyc_r;
    logic             start_r;
    logic             busy_r;
    logic             tmo_s;
    logic             tmo_fire_s;
    logic             unused_rdt_s;

    assign rd_ptr_adv_s = (rd_ptr_r == ADR_UL) ? ADR_LL : rd_ptr_r + 32'd4;

    // State register
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a pending or live flush keeps the reader parked in IDLE
    always_comb begin
        state_nxt_s = state_r;
        tmo_fire_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (flush_pend_r || i_flush) begin
                    state_nxt_s = ST_IDLE;
                end else if (i_en && (rd_ptr_r != i_wr_ptr)) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (bus.wb_ack) begin
                    state_nxt_s = ST_SEND;
                end else if (tmo_s) begin
                    state_nxt_s = ST_IDLE;
                    tmo_fire_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_SEND: begin
                state_nxt_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.tx_done) begin
                    state_nxt_s = ST_IDLE;
                end else if (tmo_s) begin
                    state_nxt_s = ST_IDLE;
                    tmo_fire_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Pointer, data, counter and registered bus outputs
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            rd_ptr_r     <= ADR_LL;
            flush_pend_r <= 1'b0;
            tx_dat_r     <= {BITS{1'b0}};
            sent_r       <= {CNT_W{1'b0}};
            cyc_r        <= 1'b0;
            start_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            cyc_r   <= (state_nxt_s == ST_READ);
            start_r <= (state_nxt_s == ST_SEND);
            busy_r  <= (state_nxt_s != ST_IDLE);
            if (state_r == ST_IDLE) begin
                // The in-flight byte's advance is overwritten here by the deferred flush
                if (flush_pend_r || i_flush) begin
                    rd_ptr_r     <= i_wr_ptr;
                    flush_pend_r <= 1'b0;
                end
            end else begin
                if (i_flush) begin
                    flush_pend_r <= 1'b1;
                end
                if ((state_r == ST_READ) && bus.wb_ack) begin
                    tx_dat_r <= bus.wb_rdt[BITS-1:0];
                end
                if ((state_r == ST_WAIT) && bus.tx_done) begin
                    rd_ptr_r <= rd_ptr_adv_s;
                    sent_r   <= sent_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else if (tmo_fire_s) begin
                    rd_ptr_r <= rd_ptr_adv_s;
                end
            end
        end
    end

`ifdef RING_RD_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             err_r;

    assign tmo_s = (tmo_cnt_r == TMO_W'(TIMEOUT - 1));
    assign o_err = err_r;

    // Watchdog counts cycles spent in READ or WAIT, restarting on every state change
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_nxt_s != state_r) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if ((state_r == ST_READ) || (state_r == ST_WAIT)) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end else begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end
    end

    // Sticky error, cleared by a flush
    always_ff @(posedge i_wb_clk or posedge i_wb_rst) begin
        if (i_wb_rst) begin
            err_r <= 1'b0;
        end else if (tmo_fire_s) begin
            err_r <= 1'b1;
        end else if (i_flush) begin
            err_r <= 1'b0;
        end
    end
`else
    assign tmo_s = 1'b0;
`endif

    assign bus.wb_adr   = rd_ptr_r;
    assign bus.wb_cyc   = cyc_r;
    assign bus.wb_we    = 1'b0;
    assign bus.wb_sel   = 4'b1111;
    assign bus.tx_dat   = tx_dat_r;
    assign bus.tx_start = start_r;
    assign o_empty      = (rd_ptr_r == i_wr_ptr);
    assign o_busy       = busy_r;
    assign o_sent       = sent_r;
    assign unused_rdt_s = ^bus.wb_rdt;

endmodule

// File: tb/tb_ble_ring_reader.sv
// Bench for ble_ring_reader: RAM and uart_tx responders, ring model built on slot-index arithmetic,
// randomized data and handshake delays.
module tb_ble_ring_reader;
    localparam logic [31:0] ADR_LL = 32'h00C0_0000;
    localparam logic [31:0] ADR_UL = 32'h00C1_0000;
    localparam int          BITS   = 8;
    localparam int          CNT_W  = 16;
    localparam int          NSLOT  = int'((ADR_UL - ADR_LL) >> 2) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic [31:0]      wr_ptr = ADR_LL;
    logic             empty;
    logic             busy;
    logic [CNT_W-1:0] sent;
`ifdef RING_RD_TIMEOUT_EN
    logic             err;
`endif

    ble_ring_reader_if #(.BITS(BITS)) bus ();

    ble_ring_reader #(
        .ADR_LL(ADR_LL), .ADR_UL(ADR_UL), .BITS(BITS), .CNT_W(CNT_W)
    ) dut (
        .i_wb_clk (clk),
        .i_wb_rst (rst),
        .i_en     (en),
        .i_flush  (flush),
        .i_wr_ptr (wr_ptr),
        .bus      (bus),
        .o_empty  (empty),
        .o_busy   (busy),
        .o_sent   (sent)
`ifdef RING_RD_TIMEOUT_EN
        ,
        .o_err    (err)
`endif
    );

    always #5 clk = ~clk;

    int              n_vec = 0;
    int              n_err = 0;
    logic [31:0]     mem [logic [31:0]];
    logic [BITS-1:0] captured [$];
    logic [31:0]     rd_adrs [$];
    logic [BITS-1:0] exp_b [$];
    logic [31:0]     exp_a [$];
    int              ack_dly = 0;
    int              done_dly = 0;
    bit              late_ack_req = 1'b0;
    int              cyc_len = 0;
    int              last_cyc_len = 0;
    bit              adr_moved = 1'b0;
    logic [31:0]     adr0 = 32'd0;
    bit              outstanding = 1'b0;
    int              done_cnt = 0;
    logic [31:0]     model_rd = ADR_LL;
    int              model_sent = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", tag, got, want);
        end
    endtask

    // Address of the slot k positions after base, counted as ring indices
    function automatic logic [31:0] slot_addr(input logic [31:0] base, input int k);
        int idx;
        idx = int'((base - ADR_LL) >> 2);
        return ADR_LL + (32'((idx + k) % NSLOT) << 2);
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        else return {a[23:0], 8'hEE};
    endfunction

    // Wishbone RAM slave: acks after ack_dly idle cycles, records each read address
    initial begin
        bus.wb_ack = 1'b0;
        bus.wb_rdt = 32'd0;
        forever begin
            @(posedge clk); #1;
            bus.wb_ack = 1'b0;
            if (late_ack_req) begin
                bus.wb_ack   = 1'b1;
                bus.wb_rdt   = 32'h0000_00A5;
                late_ack_req = 1'b0;
            end else if (bus.wb_cyc) begin
                if (cyc_len == 0) adr0 = bus.wb_adr;
                else if (bus.wb_adr !== adr0) adr_moved = 1'b1;
                cyc_len++;
                if (cyc_len > ack_dly) begin
                    bus.wb_ack   = 1'b1;
                    bus.wb_rdt   = mem_rd(bus.wb_adr);
                    rd_adrs.push_back(bus.wb_adr);
                    last_cyc_len = cyc_len;
                    cyc_len      = 0;
                end
            end else begin
                cyc_len = 0;
            end
        end
    end

    // uart_tx model: captures each started byte, answers done after done_dly cycles
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.tx_done = 1'b0;
            if (outstanding) begin
                if (done_cnt >= done_dly) begin
                    bus.tx_done = 1'b1;
                    outstanding = 1'b0;
                end else begin
                    done_cnt++;
                end
            end
            if (bus.tx_start) begin
                chk("start_overlap", {31'd0, outstanding}, 32'd0);
                outstanding = 1'b1;
                done_cnt    = 0;
                captured.push_back(bus.tx_dat);
            end
        end
    end

    task automatic fill(input int cnt, input int fixed);
        logic [31:0] a;
        logic [31:0] w;
        exp_a.delete();
        exp_b.delete();
        captured.delete();
        rd_adrs.delete();
        for (int k = 0; k < cnt; k++) begin
            a = slot_addr(model_rd, k);
            w = $urandom;
            if (fixed >= 0) w[7:0] = 8'(fixed + k);
            mem[a] = w;
            exp_a.push_back(a);
            exp_b.push_back(w[BITS-1:0]);
        end
    endtask

    task automatic wait_drained(input string tag, input int budget);
        int t;
        t = 0;
        @(posedge clk); #1;
        while ((busy || !empty) && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        chk({tag, "_drained"}, {31'd0, busy || !empty}, 32'd0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int t;
        t = 0;
        @(posedge clk); #1;
        while (busy && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_starts(input string tag, input int n, input int budget);
        int t;
        t = 0;
        while (captured.size() < n && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        chk({tag, "_started"}, 32'(captured.size()), 32'(n));
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_sent"}, 32'(sent), 32'(model_sent));
        chk({tag, "_rdptr"}, dut.rd_ptr_r, model_rd);
    endtask

    task automatic drain(input string tag, input int cnt, input int fixed);
        fill(cnt, fixed);
        wr_ptr = slot_addr(model_rd, cnt);
        en     = 1'b1;
        wait_drained(tag, 64 * cnt + 64);
        model_rd   = slot_addr(model_rd, cnt);
        model_sent = (model_sent + cnt) % (1 << CNT_W);
        chk({tag, "_starts"}, 32'(captured.size()), 32'(cnt));
        chk({tag, "_reads"}, 32'(rd_adrs.size()), 32'(cnt));
        for (int k = 0; k < cnt && k < captured.size(); k++)
            chk($sformatf("%s_byte%0d", tag, k), 32'(captured[k]), 32'(exp_b[k]));
        for (int k = 0; k < cnt && k < rd_adrs.size(); k++)
            chk($sformatf("%s_adr%0d", tag, k), rd_adrs[k], exp_a[k]);
        check_state(tag);
        chk({tag, "_empty"}, {31'd0, empty}, 32'd1);
    endtask

    task automatic do_flush(input string tag, input logic [31:0] p);
        en     = 1'b0;
        wr_ptr = p;
        flush  = 1'b1;
        @(posedge clk); #1;
        flush  = 1'b0;
        @(posedge clk); #1;
        model_rd = p;
        chk({tag, "_flush_rdptr"}, dut.rd_ptr_r, p);
        chk({tag, "_flush_empty"}, {31'd0, empty}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        int          t;
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cyc",    {31'd0, bus.wb_cyc}, 32'd0);
        chk("rst_adr",    bus.wb_adr, ADR_LL);
        chk("rst_start",  {31'd0, bus.tx_start}, 32'd0);
        chk("rst_txdat",  32'(bus.tx_dat), 32'd0);
        chk("rst_sent",   32'(sent), 32'd0);
        chk("rst_busy",   {31'd0, busy}, 32'd0);
        chk("rst_empty",  {31'd0, empty}, 32'd1);
        chk("rst_we",     {31'd0, bus.wb_we}, 32'd0);
        chk("rst_sel",    {28'd0, bus.wb_sel}, 32'hF);
        chk("rst_rdptr",  dut.rd_ptr_r, ADR_LL);
        rst = 1'b0;
        @(posedge clk); #1;

        ack_dly = 1; done_dly = 10;
        drain("basic", 3, 'h41);

        // Dropping enable while a byte is in flight lets only that byte finish
        ack_dly = 0; done_dly = 6;
        fill(3, -1);
        wr_ptr = slot_addr(model_rd, 3);
        en = 1'b1;
        wait_starts("endrop", 1, 100);
        en = 1'b0;
        wait_idle("endrop", 100);
        repeat (10) @(posedge clk);
        #1;
        model_rd = slot_addr(model_rd, 1);
        model_sent++;
        chk("endrop_starts", 32'(captured.size()), 32'd1);
        if (captured.size() > 0) chk("endrop_byte", 32'(captured[0]), 32'(exp_b[0]));
        check_state("endrop");
        chk("endrop_empty", {31'd0, empty}, 32'd0);
        drain("endrop_resume", 2, -1);

        ack_dly = 2; done_dly = 3;
        do_flush("wrap", ADR_UL);
        drain("wrap", 2, -1);

        ack_dly = 7; done_dly = 4;
        adr_moved = 1'b0;
        drain("stall", 1, -1);
        chk("stall_cyc_len", 32'(last_cyc_len), 32'd8);
        chk("stall_adr_moved", {31'd0, adr_moved}, 32'd0);

        for (int r = 0; r < 6; r++) begin
            ack_dly  = int'($urandom_range(0, 3));
            done_dly = int'($urandom_range(0, 12));
            if (r % 3 == 2) begin
                p = slot_addr(ADR_LL, NSLOT - int'($urandom_range(1, 3)));
                do_flush($sformatf("rnd%0d", r), p);
            end
            drain($sformatf("rnd%0d", r), int'($urandom_range(1, 5)), -1);
        end

        // Flush during WAIT: in-flight byte is counted, pointer jumps to the new writer slot
        ack_dly = 1; done_dly = 20;
        fill(3, -1);
        wr_ptr = slot_addr(model_rd, 3);
        en = 1'b1;
        wait_starts("flwait", 1, 100);
        @(posedge clk); #1;
        wr_ptr = 32'h00C0_0040;
        flush  = 1'b1;
        @(posedge clk); #1;
        flush  = 1'b0;
        wait_drained("flwait", 200);
        repeat (5) @(posedge clk);
        #1;
        model_rd = 32'h00C0_0040;
        model_sent++;
        chk("flwait_starts", 32'(captured.size()), 32'd1);
        if (captured.size() > 0) chk("flwait_byte", 32'(captured[0]), 32'(exp_b[0]));
        check_state("flwait");

        // Asynchronous reset in the middle of a stalled read
        ack_dly = 40; done_dly = 2;
        fill(1, -1);
        wr_ptr = slot_addr(model_rd, 1);
        en = 1'b1;
        t = 0;
        while (!bus.wb_cyc && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        chk("arst_cyc_seen", {31'd0, bus.wb_cyc}, 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("arst_cyc",   {31'd0, bus.wb_cyc}, 32'd0);
        chk("arst_busy",  {31'd0, busy}, 32'd0);
        chk("arst_sent",  32'(sent), 32'd0);
        chk("arst_rdptr", dut.rd_ptr_r, ADR_LL);
        chk("arst_adr",   bus.wb_adr, ADR_LL);
        en = 1'b0;
        #1 rst = 1'b0;
        model_rd   = ADR_LL;
        model_sent = 0;
        captured.delete();
        late_ack_req = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("arst_late_starts", 32'(captured.size()), 32'd0);
        chk("arst_late_busy",   {31'd0, busy}, 32'd0);
        check_state("arst_late");

        ack_dly = 0; done_dly = 1;
        drain("post_rst", 2, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ble_ring_reader.md
Name: ble_ring_reader

Overview:
Drains the BLE receive ring buffer, the RAM window ADR_LL..ADR_UL that the UART-rx path fills one byte per 32-bit word. It is a Wishbone read master on the shared RAM port; the top-level mux grants it the port when the CPU bus is idle. Each fetched byte (bits [7:0] of the word) is handed to a uart_tx instance through the start/done handshake, so received data is forwarded to the PC link.

Parameters:
ADR_LL, 'h00C00000, first ring slot address (word aligned)
ADR_UL, 'h00C10000, last ring slot address (inclusive, word aligned)
BITS, 8, UART payload width
CNT_W, 16, width of the sent-byte counter

Ports:
i_wb_clk  in  1  clock
i_wb_rst  in  1  asynchronous active-high reset
i_en  in  1  enable draining; when low, new fetches are not started
i_flush  in  1  discard all unread data: rd_ptr := i_wr_ptr
i_wr_ptr  in  32  writer's next-free slot address
o_wb_adr  out  32  read address (= rd_ptr while cyc)
o_wb_cyc  out  1  bus request/cycle
o_wb_we  out  1  tied 0
o_wb_sel  out  4  tied 4'b1111
i_wb_rdt  in  32  read data
i_wb_ack  in  1  read acknowledge
o_tx_dat  out  BITS  byte to uart_tx
o_tx_start  out  1  one-cycle start pulse to uart_tx
i_tx_done  in  1  uart_tx finished the byte
o_empty  out  1  rd_ptr == i_wr_ptr
o_busy  out  1  FSM not in IDLE
o_sent  out  CNT_W  bytes transmitted, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, immediate): state IDLE; rd_ptr=ADR_LL; o_wb_cyc=0; o_wb_adr=ADR_LL; o_tx_dat=0; o_tx_start=0; o_sent=0; flush_pend=0.
- Slot advance: next(p) = (p == ADR_UL) ? ADR_LL : p+4. Ring holds (ADR_UL-ADR_LL)/4+1 slots. Overflow detection belongs to the writer.
- FSM:
  IDLE: if flush_pend or i_flush, then rd_ptr<=i_wr_ptr and flush_pend<=0 (a flush takes priority over a fetch). Else if i_en && rd_ptr!=i_wr_ptr, go to READ.
  READ: o_wb_cyc=1, o_wb_adr=rd_ptr, held stable until i_wb_ack. On ack: o_tx_dat<=i_wb_rdt[BITS-1:0], go to SEND. i_wb_ack outside READ is ignored.
  SEND: o_tx_start=1 for exactly one cycle, then go to WAIT.
  WAIT: on i_tx_done: rd_ptr<=next(rd_ptr), o_sent<=o_sent+1, go to IDLE.
- Minimum per byte: 1 (IDLE) + 1 (ack in the first READ cycle) + 1 (SEND) + tx time. o_tx_start is never asserted while a byte is outstanding.
- i_flush outside IDLE sets flush_pend. The byte in flight completes and is counted. The flush applies on return to IDLE and that byte's slot advance is superseded.
- i_en dropped mid-transfer: the current byte completes; no new fetch starts.
- i_wr_ptr is sampled only in IDLE. Changes during READ/SEND/WAIT do not affect the in-flight byte.
- o_empty is combinational from rd_ptr and i_wr_ptr. o_busy = (state != IDLE).
- Reset asserted mid-READ drops o_wb_cyc in the same instant. A late ack after reset is ignored.

Optional Feature:
RING_RD_TIMEOUT_EN: adds parameter TIMEOUT (default 4096) and output o_err (1 bit, sticky, reset 0).
- A cycle counter runs in READ and WAIT and clears on state entry.
- Reaching TIMEOUT: drop o_wb_cyc, set o_err=1, advance rd_ptr (skip the slot), do not increment o_sent, return to IDLE. o_err clears only on reset or i_flush.
- Without the macro: no counter and no o_err port; READ and WAIT wait indefinitely.

Test Plan:
- Basic: write words 'h41,'h42,'h43 to slots C00000..C00008 and set i_wr_ptr='hC0000C, i_en=1, ack after 1 cycle, done 10 cycles after each start -> three start pulses with o_tx_dat 'h41,'h42,'h43 in order; o_sent=3; o_empty=1; rd_ptr='hC0000C.
- Wrap: rd_ptr preset via flush to i_wr_ptr=ADR_UL, then i_wr_ptr=ADR_LL+4 -> reads at 'hC10000 then 'hC00000; final rd_ptr='hC00004.
- Ack stall: delay i_wb_ack 7 cycles -> o_wb_cyc and o_wb_adr stable for all 7 cycles; o_tx_start only after ack; exactly one pulse.
- Flush in WAIT: assert i_flush while waiting with i_wr_ptr='hC00040 -> current byte completes, o_sent increments, rd_ptr='hC00040, no further starts.
- Async reset mid-READ: pulse i_wb_rst between clock edges -> o_wb_cyc falls immediately; rd_ptr=ADR_LL; o_sent=0; a late ack causes no start.
- (RING_RD_TIMEOUT_EN) TIMEOUT=16, never assert i_tx_done -> o_err=1 after 16 WAIT cycles; rd_ptr advanced by 4; o_sent unchanged.
